// File: rtl/cbs_pkg.sv
// cbs_pkg: shared states, default parameters and result packing for the CBS layer sequencer
package cbs_pkg;
  localparam int ADDR_W_DEF   = 6;
  localparam int DIM_W_DEF    = 6;
  localparam int RD_STEP_DEF  = 2;
  localparam int ROW_GAP_DEF  = 2;
  localparam int WR_STEP_DEF  = 2;
  localparam int PIPE_LAT_DEF = 1;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_WRITE, S_DONE} state_t;
  function automatic logic [31:0] pack_results(input logic [15:0] result1, input logic [15:0] result2);
    return {result1, result2};
  endfunction
endpackage

// File: rtl/cbs_addr_gen.sv
// cbs_addr_gen: read/write pointers and window row/col counters for one layer job
module cbs_addr_gen #(
  parameter int ADDR_W  = 6,
  parameter int DIM_W   = 6,
  parameter int RD_STEP = 2,
  parameter int ROW_GAP = 2,
  parameter int WR_STEP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic [DIM_W-1:0]  cols,
  input  logic [DIM_W-1:0]  rows,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [DIM_W-1:0]  row,
  output logic [DIM_W-1:0]  col,
  output logic              last_col,
  output logic              last_row
);
  logic [ADDR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [DIM_W-1:0]  row_q, row_d, col_q, col_d, cols_q, cols_d, rows_q, rows_d;
  logic              adv;
  assign last_col = col_q == cols_q - DIM_W'(1);
  assign last_row = row_q == rows_q - DIM_W'(1);
  // the final write of a job only moves the write pointer; window indices stay on the last window
  assign adv = step && !(last_col && last_row);
  always_comb begin
    rd_d   = load ? rd_base : adv ? rd_q + ADDR_W'(last_col ? RD_STEP + ROW_GAP : RD_STEP) : rd_q;
    wr_d   = load ? wr_base : step ? wr_q + ADDR_W'(WR_STEP) : wr_q;
    col_d  = load ? '0 : adv ? (last_col ? '0 : col_q + DIM_W'(1)) : col_q;
    row_d  = load ? '0 : (adv && last_col) ? row_q + DIM_W'(1) : row_q;
    cols_d = load ? cols : cols_q;
    rows_d = load ? rows : rows_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q   <= '0;
      wr_q   <= '0;
      row_q  <= '0;
      col_q  <= '0;
      cols_q <= '0;
      rows_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      row_q  <= row_d;
      col_q  <= col_d;
      cols_q <= cols_d;
      rows_q <= rows_d;
    end
  end
  assign rd_ptr = rd_q;
  assign wr_ptr = wr_q;
  assign row    = row_q;
  assign col    = col_q;
endmodule

// File: rtl/cbs_layer_sequencer.sv
// cbs_layer_sequencer: walks a conv-window grid, issuing fetch, latency wait and result write per window
module cbs_layer_sequencer
  import cbs_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DIM_W    = DIM_W_DEF,
  parameter int RD_STEP  = RD_STEP_DEF,
  parameter int ROW_GAP  = ROW_GAP_DEF,
  parameter int WR_STEP  = WR_STEP_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_rd_base,
  input  logic [ADDR_W-1:0] cfg_wr_base,
  input  logic [DIM_W-1:0]  cfg_cols,
  input  logic [DIM_W-1:0]  cfg_rows,
  output logic              busy,
  output logic              done,
  output logic              need_data,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DIM_W-1:0]  win_row,
  output logic [DIM_W-1:0]  win_col
);
  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              load, step, last_col, last_row;
  logic [ADDR_W-1:0] rd_ptr, wr_ptr;
  assign load = state_q == S_IDLE && start;
  assign step = state_q == S_WRITE;
  cbs_addr_gen #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W),
    .RD_STEP(RD_STEP),
    .ROW_GAP(ROW_GAP),
    .WR_STEP(WR_STEP)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .rd_base (cfg_rd_base),
    .wr_base (cfg_wr_base),
    .cols    (cfg_cols),
    .rows    (cfg_rows),
    .rd_ptr  (rd_ptr),
    .wr_ptr  (wr_ptr),
    .row     (win_row),
    .col     (win_col),
    .last_col(last_col),
    .last_row(last_row)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_q <= (cfg_cols == '0 || cfg_rows == '0) ? S_DONE : S_FETCH;
        S_FETCH: begin
          cnt_q   <= 4'(PIPE_LAT - 1);
          state_q <= PIPE_LAT == 1 ? S_WRITE : S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= S_WRITE;
        end
        S_WRITE: state_q <= (last_col && last_row) ? S_DONE : S_FETCH;
        default: state_q <= S_IDLE;
      endcase
    end
  end
  // outputs decode the state register only, so nothing combinational reaches them from start/cfg
  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_DONE;
  assign need_data = state_q == S_FETCH;
  assign we        = state_q == S_WRITE;
  assign addr      = state_q == S_FETCH ? rd_ptr : state_q == S_WRITE ? wr_ptr : '0;
endmodule

// File: tb/tb_cbs_layer_sequencer.sv
// tb_cbs_layer_sequencer: directed table and sequence checks on PIPE_LAT=1 and PIPE_LAT=3 instances
module tb_cbs_layer_sequencer;
  logic       clk = 1'b0;
  logic       rst, start1, start3;
  logic [5:0] rb, wb, cc, cr;
  logic       busy1, done1, nd1, we1, busy3, done3, nd3, we3;
  logic [5:0] addr1, row1, col1, addr3, row3, col3;
  int         pass_n = 0, tot_n = 0;
  int         rd_n, wr_n, ovl, dc, bc, cnt;
  logic [31:0] rd_pk, wr_pk, fc_pk, wc_pk;
  typedef struct {
    logic        st;
    logic [21:0] exp;
  } vec_t;
  vec_t tbl[11];

  always #5 clk = ~clk;

  cbs_layer_sequencer u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .cfg_rd_base(rb), .cfg_wr_base(wb),
    .cfg_cols(cc), .cfg_rows(cr), .busy(busy1), .done(done1), .need_data(nd1),
    .we(we1), .addr(addr1), .win_row(row1), .win_col(col1)
  );
  cbs_layer_sequencer #(.PIPE_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .cfg_rd_base(rb), .cfg_wr_base(wb),
    .cfg_cols(cc), .cfg_rows(cr), .busy(busy3), .done(done3), .need_data(nd3),
    .we(we3), .addr(addr3), .win_row(row3), .win_col(col3)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic logic [21:0] obs(input bit s3);
    return s3 ? {busy3, done3, nd3, we3, addr3, row3, col3} : {busy1, done1, nd1, we1, addr1, row1, col1};
  endfunction

  function automatic vec_t mk(input logic st, input logic b, input logic d, input logic n, input logic w,
                              input logic [5:0] a, input logic [5:0] r, input logic [5:0] c);
    vec_t v;
    v.st  = st;
    v.exp = {b, d, n, w, a, r, c};
    return v;
  endfunction

  // caller is at #1 after an edge with the DUT idle; that cycle is cycle 0
  task automatic run_job(input bit s3, input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                         input logic [5:0] r, input bit hold, input int maxc);
    logic [21:0] o;
    rd_n = 0; wr_n = 0; ovl = 0; dc = -1; bc = 0;
    rd_pk = '0; wr_pk = '0; fc_pk = '0; wc_pk = '0;
    rb = a; wb = b; cc = c; cr = r;
    if (s3) start3 = 1'b1;
    else start1 = 1'b1;
    for (int k = 1; k <= maxc && dc < 0; k++) begin
      @(posedge clk); #1;
      if (!hold) begin start1 = 1'b0; start3 = 1'b0; end
      if (hold && k == 2) begin rb = 6'd50; wb = 6'd60; cc = 6'd1; cr = 6'd1; end
      o = obs(s3);
      if (o[21]) bc++;
      if (o[19]) begin rd_n++; rd_pk = {rd_pk[25:0], o[17:12]}; fc_pk = {fc_pk[25:0], 6'(k)}; end
      if (o[18]) begin wr_n++; wr_pk = {wr_pk[25:0], o[17:12]}; wc_pk = {wc_pk[25:0], 6'(k)}; end
      if (o[19] && o[18]) ovl++;
      if (o[20]) dc = k;
    end
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
    rb = '0; wb = '0; cc = '0; cr = '0;
    tbl[0]  = mk(1, 0, 0, 0, 0, 6'd0,  6'd0, 6'd0);
    tbl[1]  = mk(0, 1, 0, 1, 0, 6'd0,  6'd0, 6'd0);
    tbl[2]  = mk(0, 1, 0, 0, 1, 6'd32, 6'd0, 6'd0);
    tbl[3]  = mk(0, 1, 0, 1, 0, 6'd2,  6'd0, 6'd1);
    tbl[4]  = mk(0, 1, 0, 0, 1, 6'd34, 6'd0, 6'd1);
    tbl[5]  = mk(0, 1, 0, 1, 0, 6'd6,  6'd1, 6'd0);
    tbl[6]  = mk(0, 1, 0, 0, 1, 6'd36, 6'd1, 6'd0);
    tbl[7]  = mk(0, 1, 0, 1, 0, 6'd8,  6'd1, 6'd1);
    tbl[8]  = mk(0, 1, 0, 0, 1, 6'd38, 6'd1, 6'd1);
    tbl[9]  = mk(0, 1, 1, 0, 0, 6'd0,  6'd1, 6'd1);
    tbl[10] = mk(0, 0, 0, 0, 0, 6'd0,  6'd1, 6'd1);
    @(posedge clk); #1;
    check("reset dut1", 32'(obs(0)), 32'd0);
    check("reset dut3", 32'(obs(1)), 32'd0);
    rst = 1'b0;
    rb = 6'd0; wb = 6'd32; cc = 6'd2; cr = 6'd2;
    for (int i = 0; i < 11; i++) begin
      start1 = tbl[i].st;
      check($sformatf("tbl cyc%0d", i), 32'(obs(0)), 32'(tbl[i].exp));
      @(posedge clk); #1;
    end

    run_job(1, 6'd10, 6'd40, 6'd3, 6'd1, 0, 30);
    check("lat3 done cyc", dc, 13);
    check("lat3 busy cycles", bc, 13);
    check("lat3 reads", rd_pk, 32'({6'd10, 6'd12, 6'd14}));
    check("lat3 writes", wr_pk, 32'({6'd40, 6'd42, 6'd44}));
    check("lat3 fetch cycles", fc_pk, 32'({6'd1, 6'd5, 6'd9}));
    check("lat3 write cycles", wc_pk, 32'({6'd4, 6'd8, 6'd12}));
    check("lat3 overlap", ovl, 0);
    @(posedge clk); #1;

    run_job(0, 6'd0, 6'd0, 6'd0, 6'd5, 0, 10);
    check("zero done cyc", dc, 1);
    check("zero busy cycles", bc, 1);
    check("zero ram access", rd_n + wr_n, 0);
    @(posedge clk); #1;
    check("zero after", 32'({busy1, done1, nd1, we1}), 32'd0);

    run_job(0, 6'd62, 6'd62, 6'd2, 6'd1, 0, 20);
    check("wrap reads", rd_pk, 32'({6'd62, 6'd0}));
    check("wrap writes", wr_pk, 32'({6'd62, 6'd0}));
    check("wrap done cyc", dc, 5);
    @(posedge clk); #1;

    rb = 6'd10; wb = 6'd40; cc = 6'd3; cr = 6'd1;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("second wait", 32'(obs(1)), 32'h200000);
    #2 rst = 1'b1;
    #1 check("async rst", 32'(obs(1)), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (we3 || done3 || busy3) cnt++;
      @(posedge clk); #1;
    end
    check("no activity after rst", cnt, 0);
    run_job(1, 6'd20, 6'd50, 6'd1, 6'd1, 0, 20);
    check("post-rst done cyc", dc, 5);
    check("post-rst reads", rd_pk, 32'd20);
    check("post-rst writes", wr_pk, 32'd50);

    run_job(0, 6'd4, 6'd20, 6'd2, 6'd1, 1, 20);
    check("hold done cyc", dc, 5);
    check("hold reads", rd_pk, 32'({6'd4, 6'd6}));
    check("hold writes", wr_pk, 32'({6'd20, 6'd22}));
    @(posedge clk); #1;
    check("hold gap idle", 32'({busy1, nd1}), 32'd0);
    @(posedge clk); #1;
    start1 = 1'b0;
    check("job2 fetch", 32'({busy1, nd1, addr1}), 32'({1'b1, 1'b1, 6'd50}));
    @(posedge clk); #1;
    check("job2 write", 32'({we1, addr1}), 32'({1'b1, 6'd60}));
    @(posedge clk); #1;
    check("job2 done", 32'(done1), 32'd1);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
